// File: rtl/hdmi_pkg.sv
// Shared constants, types and the BCH parity step for the HDMI data-island path.
package hdmi_pkg;

    localparam int PACKET_CYCLES      = 32;
    localparam int HEADER_DATA_CYCLES = 24;
    localparam int SUB_DATA_CYCLES    = 28;
    localparam int SUBPACKETS         = 4;
    localparam int SUBPACKET_BITS     = 56;

    localparam logic [7:0] DEFAULT_ECC_POLY = 8'b1000_0011;

    typedef logic [23:0] header_t;
    typedef logic [55:0] subpacket_t;

    // One LSB-first LFSR step of G(x)=1+x^6+x^7+x^8; poly is the feedback mask.
    function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic data_bit,
                                            input logic [7:0] poly);
        logic [7:0] shifted;
        shifted = ecc >> 1;
        bch_step = (ecc[0] ^ data_bit) ? (shifted ^ poly) : shifted;
    endfunction

endpackage

// File: rtl/bch_ecc_lane.sv
// BCH parity accumulator for one packet lane; absorbs BITS_PER_CYCLE bits per
// advance, bit 0 first.
module bch_ecc_lane
    import hdmi_pkg::*;
#(
    parameter int         BITS_PER_CYCLE = 1,
    parameter logic [7:0] ECC_POLY       = DEFAULT_ECC_POLY
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      advance,
    input  logic [BITS_PER_CYCLE-1:0] data,
    output logic [7:0]                ecc
);

    logic [7:0] ecc_next;

    always_comb begin
        ecc_next = ecc;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            ecc_next = bch_step(ecc_next, data[b], ECC_POLY);
        end
    end

    // Clear wins over advance so a wrap or an early island end starts the next packet clean.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ecc <= 8'h00;
        end else if (advance) begin
            ecc <= ecc_next;
        end
    end

endmodule

// File: rtl/data_island_packet_assembler.sv
// Serialises one 32-cycle HDMI data-island packet (header + 4 subpackets) with BCH parity.
// Optional build macro PKT_ECC_INJECT_EN adds inject_ecc_err to corrupt header parity bit 0.
module data_island_packet_assembler
    import hdmi_pkg::*;
#(
    parameter logic [7:0] ECC_POLY = DEFAULT_ECC_POLY
) (
    input  logic         clk_pixel,
    input  logic         reset,
    input  logic         data_island_period,
    input  logic [23:0]  header,
    input  logic [223:0] sub,
`ifdef PKT_ECC_INJECT_EN
    input  logic         inject_ecc_err,
`endif
    output logic         packet_start,
    output logic [8:0]   packet_data,
    output logic         packet_valid,
    output logic [4:0]   packet_counter,
    output logic         packet_abort
);

    logic [4:0]   cnt;
    header_t      header_q;
    logic [223:0] sub_q;

    logic         capture;
    logic         last_cycle;
    logic         hdr_phase;
    logic         sub_phase;
    logic         clear_ecc;
    header_t      hdr_cur;
    logic [223:0] sub_cur;
    logic         hdr_bit;
    logic [7:0]   ecc_h;
    logic [7:0]   ecc_s    [SUBPACKETS];
    logic [1:0]   sub_bits [SUBPACKETS];
    logic [8:0]   word;

`ifdef PKT_ECC_INJECT_EN
    logic         inject_q;
`endif

    assign capture    = data_island_period && (cnt == 5'd0);
    assign last_cycle = (cnt == 5'(PACKET_CYCLES - 1));
    assign hdr_phase  = (cnt < 5'(HEADER_DATA_CYCLES));
    assign sub_phase  = (cnt < 5'(SUB_DATA_CYCLES));
    assign clear_ecc  = !data_island_period || last_cycle;

    // Cycle 0 serialises straight from the live inputs while the shadow copy is loaded.
    assign hdr_cur = (cnt == 5'd0) ? header : header_q;
    assign sub_cur = (cnt == 5'd0) ? sub    : sub_q;
    assign hdr_bit = hdr_cur[cnt];

    assign packet_start = capture && !reset;

    bch_ecc_lane #(
        .BITS_PER_CYCLE (1),
        .ECC_POLY       (ECC_POLY)
    ) u_ecc_header (
        .clk     (clk_pixel),
        .reset   (reset),
        .clear   (clear_ecc),
        .advance (data_island_period && hdr_phase),
        .data    (hdr_bit),
        .ecc     (ecc_h)
    );

    for (genvar i = 0; i < SUBPACKETS; i++) begin : g_sub
        subpacket_t lane_bits;

        assign lane_bits   = sub_cur[i*SUBPACKET_BITS +: SUBPACKET_BITS];
        assign sub_bits[i] = {lane_bits[{cnt, 1'b1}], lane_bits[{cnt, 1'b0}]};

        bch_ecc_lane #(
            .BITS_PER_CYCLE (2),
            .ECC_POLY       (ECC_POLY)
        ) u_ecc_sub (
            .clk     (clk_pixel),
            .reset   (reset),
            .clear   (clear_ecc),
            .advance (data_island_period && sub_phase),
            .data    (sub_bits[i]),
            .ecc     (ecc_s[i])
        );
    end

    // Data bits first, then the frozen parity byte indexed by the offset into the parity phase.
    always_comb begin
        word    = 9'd0;
        word[0] = hdr_phase ? hdr_bit : ecc_h[cnt[2:0]];
`ifdef PKT_ECC_INJECT_EN
        if (cnt == 5'(HEADER_DATA_CYCLES)) begin
            word[0] = word[0] ^ inject_q;
        end
`endif
        for (int i = 0; i < SUBPACKETS; i++) begin
            word[1+i] = sub_phase ? sub_bits[i][0] : ecc_s[i][{cnt[1:0], 1'b0}];
            word[5+i] = sub_phase ? sub_bits[i][1] : ecc_s[i][{cnt[1:0], 1'b1}];
        end
    end

    // packet_valid qualifies packet_data/packet_counter one cycle after the cnt they describe;
    // there is no back-pressure, the TMDS side consumes every valid word.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            cnt            <= 5'd0;
            header_q       <= '0;
            sub_q          <= '0;
            packet_data    <= 9'd0;
            packet_valid   <= 1'b0;
            packet_counter <= 5'd0;
            packet_abort   <= 1'b0;
        end else begin
            packet_valid   <= data_island_period;
            packet_data    <= data_island_period ? word : 9'd0;
            packet_counter <= data_island_period ? cnt : 5'd0;
            packet_abort   <= !data_island_period && (cnt != 5'd0);
            cnt            <= data_island_period ? cnt + 5'd1 : 5'd0;
            if (capture) begin
                header_q <= header;
                sub_q    <= sub;
            end
        end
    end

`ifdef PKT_ECC_INJECT_EN
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            inject_q <= 1'b0;
        end else if (capture) begin
            inject_q <= inject_ecc_err;
        end
    end
`endif

endmodule

// File: tb/tb_data_island_packet_assembler.sv
// Directed bench for data_island_packet_assembler: null/known packets, back-to-back,
// early island end, mid-packet reset and (with PKT_ECC_INJECT_EN) parity injection.
module tb_data_island_packet_assembler;

    logic         clk_pixel = 1'b0;
    logic         reset;
    logic         data_island_period;
    logic [23:0]  header;
    logic [223:0] sub;
    logic         inject_ecc_err;
    logic         packet_start;
    logic [8:0]   packet_data;
    logic         packet_valid;
    logic [4:0]   packet_counter;
    logic         packet_abort;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [8:0]   exp_q[$];
    logic [8:0]   obs_words [32];
    logic [8:0]   t3_words  [32];
    logic [23:0]  t3_h;
    logic [223:0] t3_s;
    logic [23:0]  rh;
    logic [223:0] rs;
    logic [7:0]   par;

    data_island_packet_assembler dut (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .data_island_period (data_island_period),
        .header             (header),
        .sub                (sub),
`ifdef PKT_ECC_INJECT_EN
        .inject_ecc_err     (inject_ecc_err),
`endif
        .packet_start       (packet_start),
        .packet_data        (packet_data),
        .packet_valid       (packet_valid),
        .packet_counter     (packet_counter),
        .packet_abort       (packet_abort)
    );

    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] ref_step(input logic [7:0] e, input logic b);
        logic [7:0] x;
        x = {1'b0, e[7:1]};
        if (e[0] != b) x = x ^ 8'h83;
        return x;
    endfunction

    // Reference packet: 32 expected words pushed onto exp_q.
    task automatic build_expected(input logic [23:0] h, input logic [223:0] s, input logic inj);
        logic [7:0]  eh;
        logic [7:0]  es [4];
        logic [55:0] lane;
        logic [8:0]  w;
        eh = 8'h00;
        for (int i = 0; i < 4; i++) es[i] = 8'h00;
        for (int k = 0; k < 32; k++) begin
            w = 9'd0;
            if (k < 24) begin
                w[0] = h[k];
                eh   = ref_step(eh, h[k]);
            end else begin
                w[0] = eh[k-24] ^ (inj && (k == 24));
            end
            for (int i = 0; i < 4; i++) begin
                lane = s[i*56 +: 56];
                if (k < 28) begin
                    w[1+i] = lane[2*k];
                    w[5+i] = lane[2*k+1];
                    es[i]  = ref_step(ref_step(es[i], lane[2*k]), lane[2*k+1]);
                end else begin
                    w[1+i] = es[i][2*(k-28)];
                    w[5+i] = es[i][2*(k-28)+1];
                end
            end
            exp_q.push_back(w);
        end
    endtask

    task automatic drive(input logic isl, input logic [23:0] h, input logic [223:0] s, input logic inj);
        data_island_period = isl;
        header             = h;
        sub                = s;
        inject_ecc_err     = inj;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    // Runs the first n cycles of a packet with the island high; inputs are garbage after capture.
    task automatic run_packet(input string tag, input logic [23:0] h, input logic [223:0] s,
                              input logic inj, input int n);
        logic [8:0] exp_w;
        exp_q.delete();
        build_expected(h, s, inj);
        for (int k = 0; k < n; k++) begin
            if (k == 0) drive(1'b1, h, s, inj);
            else        drive(1'b1, ~h, ~s, ~inj);
            check($sformatf("%s k=%0d start", tag, k), packet_start, (k == 0));
            tick();
            exp_w = exp_q.pop_front();
            check($sformatf("%s k=%0d valid", tag, k), packet_valid, 1);
            check($sformatf("%s k=%0d counter", tag, k), packet_counter, k);
            check($sformatf("%s k=%0d data", tag, k), packet_data, exp_w);
            check($sformatf("%s k=%0d abort", tag, k), packet_abort, 0);
            obs_words[k] = packet_data;
        end
        exp_q.delete();
    endtask

    task automatic idle(input string tag, input int n);
        for (int j = 0; j < n; j++) begin
            drive(1'b0, 24'h5A5A5A, {4{56'h00C0FFEE_123456}}, 1'b1);
            check($sformatf("%s idle%0d start", tag, j), packet_start, 0);
            tick();
            check($sformatf("%s idle%0d valid", tag, j), packet_valid, 0);
            check($sformatf("%s idle%0d data", tag, j), packet_data, 0);
            check($sformatf("%s idle%0d counter", tag, j), packet_counter, 0);
            check($sformatf("%s idle%0d abort", tag, j), packet_abort, 0);
        end
    endtask

    function automatic logic [223:0] rand_sub();
        logic [223:0] r;
        for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        // Reset state
        reset = 1'b1;
        drive(1'b0, 24'h0, 224'h0, 1'b0);
        tick();
        tick();
        drive(1'b1, 24'h123456, 224'h0, 1'b0);
        check("reset start", packet_start, 0);
        tick();
        check("reset valid", packet_valid, 0);
        check("reset data", packet_data, 0);
        check("reset counter", packet_counter, 0);
        check("reset abort", packet_abort, 0);
        drive(1'b0, 24'h0, 224'h0, 1'b0);
        reset = 1'b0;
        idle("post_reset", 1);

        // Test 1: null packet, then island falls exactly at the wrap
        run_packet("t1", 24'h0, 224'h0, 1'b0, 32);
        for (int k = 0; k < 32; k++) check($sformatf("t1 k=%0d zero", k), obs_words[k], 0);
        idle("t1", 2);

        // Test 2: single header bit, parity byte 8'h4A
        run_packet("t2", 24'h000001, 224'h0, 1'b0, 32);
        check("t2 word0", obs_words[0], 9'h001);
        for (int k = 1; k < 24; k++) check($sformatf("t2 k=%0d hdr", k), obs_words[k][0], 0);
        for (int k = 0; k < 32; k++) check($sformatf("t2 k=%0d sub", k), obs_words[k][8:1], 0);
        for (int k = 0; k < 8; k++) par[k] = obs_words[24+k][0];
        check("t2 parity", par, 8'h4A);
        idle("t2", 1);

        // Test 3: three random packets back to back
        t3_h = $urandom;
        t3_s = rand_sub();
        run_packet("t3p0", t3_h, t3_s, 1'b0, 32);
        for (int k = 0; k < 32; k++) t3_words[k] = obs_words[k];
        rh = $urandom;
        rs = rand_sub();
        run_packet("t3p1", rh, rs, 1'b0, 32);
        rh = $urandom;
        rs = rand_sub();
        run_packet("t3p2", rh, rs, 1'b0, 32);
        idle("t3", 1);

        // Test 4: island drops at counter 10, returns 5 cycles later
        run_packet("t4a", 24'hABCDEF, {56'h0123456789ABCD, 56'hFEDCBA98765432, 56'h0F0F0F0F0F0F0F, 56'hF0F0F0F0F0F0F0}, 1'b0, 10);
        drive(1'b0, 24'h0, 224'h0, 1'b0);
        check("t4 drop start", packet_start, 0);
        tick();
        check("t4 abort", packet_abort, 1);
        check("t4 drop valid", packet_valid, 0);
        check("t4 drop data", packet_data, 0);
        check("t4 drop counter", packet_counter, 0);
        idle("t4", 4);
        run_packet("t4b", 24'h00F00D, {56'h1, 56'h2, 56'h80000000000000, 56'h55555555555555}, 1'b0, 32);
        idle("t4b", 1);

        // Test 5: reset at counter 17
        run_packet("t5a", 24'h13579B, {4{56'h2468ACE0246802}}, 1'b0, 17);
        reset = 1'b1;
        drive(1'b1, 24'h13579B, {4{56'h2468ACE0246802}}, 1'b0);
        check("t5 rst start", packet_start, 0);
        tick();
        check("t5 rst valid", packet_valid, 0);
        check("t5 rst data", packet_data, 0);
        check("t5 rst counter", packet_counter, 0);
        check("t5 rst abort", packet_abort, 0);
        tick();
        reset = 1'b0;
        run_packet("t5b", 24'hC0FFEE, {56'hDEADBEEF000001, 56'h0, 56'hFFFFFFFFFFFFFF, 56'h3}, 1'b0, 32);
        idle("t5b", 1);

`ifdef PKT_ECC_INJECT_EN
        // Test 6: parity injection affects only k=24 header bit of one packet
        run_packet("t6inj", t3_h, t3_s, 1'b1, 32);
        for (int k = 0; k < 32; k++)
            check($sformatf("t6 k=%0d vs t3", k), obs_words[k], t3_words[k] ^ ((k == 24) ? 9'h001 : 9'h000));
        run_packet("t6clean", t3_h, t3_s, 1'b0, 32);
        check("t6 clean k24", obs_words[24], t3_words[24]);
        idle("t6", 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
